// File: rtl/ucd_io_pkg.sv
// Shared constants for the UCD I/O stages (LED, button, DIP debounce).
// Defaults assume a 100 MHz clock with a 1 ms sample tick.
package ucd_io_pkg;

  localparam int DEF_WIDTH          = 24;
  localparam int DEF_TICK_DIV       = 100000;
  localparam int DEF_STABLE_SAMPLES = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch channel: two-flop synchronizer, sample history advanced on the
// shared tick, and a stable flag for the window that includes the incoming sample.
module debounce_bit
  import ucd_io_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic tick,
  output logic level,
  output logic stable
);

  logic                      meta;
  logic                      sync;
  logic [STABLE_SAMPLES-2:0] hist;
  logic [STABLE_SAMPLES-1:0] window;

  // The window is the stored samples plus the one arriving this tick, so
  // qualification happens on the same edge that records the last sample.
  assign window = {hist, sync};
  assign level  = sync;
  assign stable = (&window) | ~(|window);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= '0;
    end else begin
      meta <= din;
      sync <= meta;
      if (tick) hist <= window[STABLE_SAMPLES-2:0];
    end
  end

endmodule

// File: rtl/dip_debounce.sv
// DIP switch debouncer: shared prescaler, per-channel debounce_bit instances,
// and group-wide change aggregation into dip_out / dip_change / change_mask.
module dip_debounce
  import ucd_io_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dip_in,
  output logic [WIDTH-1:0] dip_out,
  output logic             dip_change,
  output logic [WIDTH-1:0] change_mask,
  output logic             sample_tick
);

  localparam int            CW       = cnt_bits(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] flip;

  // Reset leaves cnt at 0, so the strobe is low in reset without its own flop.
  assign sample_tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (sample_tick) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  debounce_bit #(
    .STABLE_SAMPLES(STABLE_SAMPLES)
  ) u_bit [WIDTH-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (dip_in),
    .tick  (sample_tick),
    .level (level),
    .stable(stable)
  );

  assign flip = {WIDTH{sample_tick}} & stable & (level ^ dip_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dip_out     <= '0;
      dip_change  <= 1'b0;
      change_mask <= '0;
    end else begin
      dip_out    <= dip_out ^ flip;
      dip_change <= |flip;
      if (|flip) change_mask <= flip;
    end
  end

endmodule

// File: tb/tb_dip_debounce.sv
// Directed + randomized bench for dip_debounce against a window-of-samples
// reference model (TICK_DIV=4, STABLE_SAMPLES=3, WIDTH=24).
module tb_dip_debounce;

  localparam int WIDTH          = 24;
  localparam int TICK_DIV       = 4;
  localparam int STABLE_SAMPLES = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [WIDTH-1:0] dip_in = '1;
  logic [WIDTH-1:0] dip_out;
  logic             dip_change;
  logic [WIDTH-1:0] change_mask;
  logic             sample_tick;

  dip_debounce #(
    .WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .STABLE_SAMPLES(STABLE_SAMPLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dip_in(dip_in), .dip_out(dip_out),
    .dip_change(dip_change), .change_mask(change_mask), .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: input delayed two edges, a list of tick samples, and the
  // rule "accept a level once the last STABLE_SAMPLES samples agree".
  logic [WIDTH-1:0] m_dly[2];
  logic [WIDTH-1:0] m_win[$];
  logic [WIDTH-1:0] m_out, m_mask;
  logic             m_chg;
  int               m_edge;

  function automatic void model_reset();
    m_dly[0] = '0; m_dly[1] = '0;
    m_win.delete();
    for (int i = 0; i < STABLE_SAMPLES-1; i++) m_win.push_back('0);
    m_out = '0; m_mask = '0; m_chg = 1'b0; m_edge = 0;
  endfunction

  function automatic void model_edge(input logic [WIDTH-1:0] din, input logic rst);
    logic [WIDTH-1:0] all1, any1, flips;
    if (!rst) begin
      model_reset();
      return;
    end
    m_chg = 1'b0;
    if ((m_edge % TICK_DIV) == TICK_DIV-1) begin
      m_win.push_back(m_dly[1]);
      if (m_win.size() > STABLE_SAMPLES) void'(m_win.pop_front());
      all1 = '1; any1 = '0;
      foreach (m_win[i]) begin all1 &= m_win[i]; any1 |= m_win[i]; end
      flips = (all1 & ~m_out) | (~any1 & m_out);
      if (flips != '0) begin m_out ^= flips; m_mask = flips; m_chg = 1'b1; end
    end
    m_dly[1] = m_dly[0];
    m_dly[0] = din;
    m_edge++;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic exp_tick;
    exp_tick = ((m_edge % TICK_DIV) == TICK_DIV-1);
    chk("dip_out", dip_out, m_out);
    chk("change_mask", change_mask, m_mask);
    chk("dip_change", dip_change, m_chg);
    chk("sample_tick", sample_tick, exp_tick);
  endtask

  task automatic cycle();
    logic [WIDTH-1:0] d;
    logic r;
    d = dip_in; r = rst_n;
    @(posedge clk); #1;
    model_edge(d, r);
    check_all();
  endtask

  initial begin
    int n, nchg, ticks, consec, gap_bad, last_tick;
    logic prev_tick;

    // Reset with all switches on; release, then expect all on at the 3rd tick.
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    chk("rst_dip_out", dip_out, 0);
    chk("rst_tick", sample_tick, 0);
    repeat (3) cycle();
    rst_n = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!dip_change && n < 40);
    chk("release_latency", n, 3*TICK_DIV);
    chk("release_dip_out", dip_out, 24'hFFFFFF);
    chk("release_mask", change_mask, 24'hFFFFFF);
    cycle();
    chk("release_pulse_len", dip_change, 0);

    dip_in = '0;
    repeat (20) cycle();
    chk("all_off", dip_out, 0);

    // Short glitch on bit 0.
    nchg = 0;
    dip_in[0] = 1'b1;
    repeat (5) begin cycle(); nchg += dip_change; end
    dip_in[0] = 1'b0;
    repeat (20) begin cycle(); nchg += dip_change; end
    chk("glitch_no_change", nchg, 0);
    chk("glitch_dip_out", dip_out, 0);

    // Two bits rising together.
    dip_in[3] = 1'b1; dip_in[17] = 1'b1;
    nchg = 0; n = 0;
    do begin cycle(); n++; nchg += dip_change; end while (!dip_change && n < 30);
    chk("pair_mask", change_mask, 24'h020008);
    chk("pair_dip_out", dip_out, 24'h020008);
    repeat (10) begin cycle(); nchg += dip_change; end
    chk("pair_single_pulse", nchg, 1);

    // Bit 5 toggling every 3 cycles, then held high.
    nchg = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) dip_in[5] = ~dip_in[5];
      cycle();
      nchg += dip_change;
    end
    chk("toggle_no_change", nchg, 0);
    dip_in[5] = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!dip_out[5] && n < 2+3*TICK_DIV+1);
    chk("hold_dip_out5", dip_out[5], 1);
    chk("hold_within_bound", (n <= 2+3*TICK_DIV+1), 1);

    // Reset with two of three samples collected on bit 9.
    dip_in[9] = 1'b1;
    n = 0;
    do begin cycle(); n++; end
    while (!(m_win[m_win.size()-1][9] && m_win[m_win.size()-2][9]) && n < 40);
    chk("two_samples_dip_out9", dip_out[9], 0);
    rst_n = 1'b0;
    #1 model_reset();
    check_all();
    chk("midrst_dip_out", dip_out, 0);
    chk("midrst_mask", change_mask, 0);
    chk("midrst_change", dip_change, 0);
    repeat (2) cycle();
    rst_n = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!dip_change && n < 40);
    chk("midrst_relatency", n, 3*TICK_DIV);
    chk("midrst_remask", change_mask, 24'h020228);

    // Randomized sparse switch activity.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(7) == 0) dip_in ^= WIDTH'($urandom & $urandom & $urandom);
      cycle();
    end

    // Free-running prescaler observation.
    ticks = 0; consec = 0; gap_bad = 0; last_tick = -1; prev_tick = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(9) == 0) dip_in[$urandom_range(WIDTH-1)] ^= 1'b1;
      cycle();
      if (sample_tick) begin
        ticks++;
        if (prev_tick) consec++;
        if (last_tick >= 0 && i - last_tick != TICK_DIV) gap_bad++;
        last_tick = i;
      end
      prev_tick = sample_tick;
    end
    chk("tick_count", ticks, 100/TICK_DIV);
    chk("tick_back_to_back", consec, 0);
    chk("tick_period", gap_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
